// File: rtl/div_seq.sv
// Sequencer for the EX-stage 32-bit divider (DIV/DIVU): restoring shift-subtract over
// 32 cycles, sign correction, and a stall request while the result is pending.
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] dividend_abs, divisor_abs;
    logic [32:0] diff;
    logic [31:0] quot_fix, rem_fix;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign dividend_abs = (signed_div_i && opdata1_i[31]) ? 32'd0 - opdata1_i : opdata1_i;
    assign divisor_abs  = (signed_div_i && opdata2_i[31]) ? 32'd0 - opdata2_i : opdata2_i;

    assign diff     = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    assign quot_fix = neg_quot_q ? 32'd0 - work_q[31:0]  : work_q[31:0];
    assign rem_fix  = neg_rem_q  ? 32'd0 - work_q[64:33] : work_q[64:33];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            StFree: begin
                result_d = 64'd0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = StByZero;
                    end else begin
                        state_d    = StOn;
                        divisor_d  = divisor_abs;
                        neg_quot_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_d  = signed_div_i && opdata1_i[31];
                        work_d     = {32'd0, dividend_abs, 1'b0};
                        cnt_d      = 6'd0;
                    end
                end
            end
            StByZero: begin
                work_d   = 65'd0;
                result_d = 64'd0;
                ready_d  = 1'b1;
                state_d  = StEnd;
            end
            StOn: begin
                if (annul_i) begin
                    state_d = StFree;
                    cnt_d   = 6'd0;
                    ready_d = 1'b0;
                end else if (cnt_q != 6'd32) begin
                    if (diff[32]) begin
                        work_d = {work_q[63:0], 1'b0};
                    end else begin
                        work_d = {diff[31:0], work_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                    state_d  = StEnd;
                    cnt_d    = 6'd0;
                end
            end
            StEnd: begin
                if (!start_i || annul_i) begin
                    state_d  = StFree;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d = StFree;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StFree;
            cnt_q      <= 6'd0;
            work_q     <= 65'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, results, divide-by-zero, annul, reset and handshake.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int tests;
    int fails;

    div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .stallreq_o  (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        step();
        step();
        tests++;
        if (ready_o !== 1'b0 || result_o !== 64'd0 || stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: ready=%b result=%h stall=%b, required 0/0/0",
                     ready_o, result_o, stallreq_o);
        end
        rst = 1'b1;
        step();
    endtask

    // Issues one request, checks latency, stall window, result, hold and release.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_res, input int exp_lat, input int hold,
                           input string name);
        int edges;
        int stalls;
        int bad_hold;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        #1;
        edges  = 0;
        stalls = 0;
        while (ready_o !== 1'b1 && edges < 100) begin
            if (stallreq_o === 1'b1) stalls++;
            step();
            edges++;
            // Operands after the accept edge must be ignored.
            if (edges == 1) begin
                opdata1_i = 32'hDEADBEEF;
                opdata2_i = 32'h00000003;
            end
        end
        tests++;
        if (edges != exp_lat) begin
            fails++;
            $display("FAIL %s latency: got %0d edges, required %0d", name, edges, exp_lat);
        end
        tests++;
        if (stalls != exp_lat) begin
            fails++;
            $display("FAIL %s stall_cycles: got %0d, required %0d", name, stalls, exp_lat);
        end
        tests++;
        if (result_o !== exp_res) begin
            fails++;
            $display("FAIL %s result: got %h, required %h", name, result_o, exp_res);
        end
        tests++;
        if (stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL %s stall_at_ready: got %b, required 0", name, stallreq_o);
        end
        bad_hold = 0;
        for (int i = 0; i < hold; i++) begin
            step();
            if (ready_o !== 1'b1 || result_o !== exp_res) bad_hold++;
        end
        if (hold > 0) begin
            tests++;
            if (bad_hold != 0) begin
                fails++;
                $display("FAIL %s hold: %0d unstable cycles, required 0", name, bad_hold);
            end
        end
        start_i = 1'b0;
        step();
        tests++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL %s release: ready=%b result=%h, required 0/0", name, ready_o, result_o);
        end
    endtask

    task automatic test_unsigned();
        run_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, 0, "udiv_100_7");
        run_div(1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 34, 0, "udiv_max_16");
        run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 34, 0, "udiv_big");
    endtask

    task automatic test_signed();
        run_div(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 0, "sdiv_m7_2");
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34, 0, "sdiv_min_m1");
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 34, 0, "sdiv_7_m2");
    endtask

    task automatic test_div_by_zero();
        run_div(1'b0, 32'd5, 32'd0, 64'd0, 2, 0, "udiv_by_zero");
        run_div(1'b1, 32'd5, 32'd0, 64'd0, 2, 0, "sdiv_by_zero");
    endtask

    task automatic test_annul();
        int rises;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (11) step();
        annul_i = 1'b1;
        start_i = 1'b0;
        step();
        annul_i = 1'b0;
        rises   = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o !== 1'b0) rises++;
            step();
        end
        tests++;
        if (rises != 0) begin
            fails++;
            $display("FAIL annul_no_ready: ready high %0d cycles, required 0", rises);
        end
        run_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, 0, "after_annul");
    endtask

    task automatic test_reset_mid();
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (21) step();
        rst = 1'b0;
        step();
        tests++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL reset_mid: ready=%b result=%h, required 0/0", ready_o, result_o);
        end
        rst     = 1'b1;
        start_i = 1'b0;
        step();
        run_div(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 0, "after_reset");
    endtask

    task automatic test_reset_in_end();
        int n;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        n = 0;
        while (ready_o !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        rst = 1'b0;
        step();
        tests++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL reset_in_end: ready=%b result=%h, required 0/0", ready_o, result_o);
        end
        rst     = 1'b1;
        start_i = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        run_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, 5, "handshake_hold");
        run_div(1'b0, 32'd5, 32'd0, 64'd0, 2, 3, "zero_hold");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_annul();
        test_reset_mid();
        test_reset_in_end();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Sequencer for the iterative 32-bit divider that the execute stage uses for DIV/DIVU. It accepts a divide request from EX and runs a 32-step restoring shift-subtract loop. It then applies sign correction and returns a 64-bit {remainder, quotient} result. While the result is pending it raises a stall request so the pipeline controller can freeze the stages upstream of EX.

## Interface
Parameters: none (widths fixed by the 32-bit register bus).
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- signed_div_i  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU); sampled with start
- opdata1_i  in  32  dividend; sampled on the accepting edge
- opdata2_i  in  32  divisor; sampled on the accepting edge
- start_i  in  1  request level from EX; must stay high until ready_o is seen
- annul_i  in  1  cancel the in-flight divide (flush or exception)
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid while ready_o=1, else 0
- ready_o  out  1  result valid
- stallreq_o  out  1  combinational: start_i & ~ready_o

## Operation
- States: FREE, BYZERO, ON, END. Reset state is FREE with cnt=0, result_o=0, ready_o=0.
- **FREE**
  - start_i=1 and annul_i=0, divisor=0: go to BYZERO.
  - start_i=1 and annul_i=0, divisor≠0: go to ON.
    - Latch the absolute values. In signed mode a negative operand becomes its two's complement; 0x80000000 stays 0x80000000 and is treated as unsigned.
    - Latch the sign flags.
    - Set the 65-bit work register to {32'b0, |dividend|, 1'b0}.
    - Set cnt=0.
  - Otherwise stay in FREE; ready_o=0 and result_o=0.
- **BYZERO**: clear the work register and go to END.
- **ON**
  - annul_i=1: go to FREE, clear cnt, keep ready_o=0. annul_i has priority over every other transition.
  - cnt<32: one restoring step per cycle.
    - diff = {1'b0, work[63:32]} - {1'b0, |divisor|}.
    - diff negative: work = work<<1.
    - Otherwise: work = {diff[31:0], work[31:0], 1'b1}.
    - cnt increments.
  - cnt=32: quotient = work[31:0], remainder = work[64:33].
    - Signed mode only: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative.
    - Register {rem, quot} into result_o, set ready_o=1, go to END, clear cnt.
- **END**
  - start_i=1: hold result_o and ready_o.
  - start_i=0: go to FREE; result_o=0 and ready_o=0 on that edge.
  - annul_i in END: same as start_i=0.
- Arithmetic is modulo 2^32. Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (no trap).
- Divide by zero returns result_o=0, signed or unsigned.

## Timing
- Accept edge E0: start_i sampled high in FREE.
- Nonzero divisor: E1..E32 perform the iterations. E33 loads result_o and sets ready_o, which is visible in the cycle after E33. Latency is 34 edges from request to consumable result.
- Zero divisor: E1 moves BYZERO to END with ready_o=1. The result is visible after E1.
- stallreq_o is high from the first cycle start_i is high until ready_o=1. It has no register delay.
- After start_i falls, ready_o drops on the next edge. A new request can be accepted on the edge after that, once the block is back in FREE.
- Reset (rst=0) at any edge, including mid-ON or in END, forces FREE, cnt=0, result_o=0, ready_o=0. Reset overrides annul_i and start_i.
- Operands changing during ON are ignored; only the values latched at E0 are used.

## Test plan
- Unsigned: opdata1=100, opdata2=7, start held. Required:
  - ready_o rises after E33.
  - result_o = {32'h2, 32'hE}.
  - stallreq_o=1 for the 34 cycles before that.
- Signed: -7 / 2, i.e. opdata1=0xFFFFFFF9, opdata2=0x2. Required: result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}. Also 0x80000000 / 0xFFFFFFFF must give {32'h0, 32'h80000000}.
- Divide by zero: 5/0, unsigned and signed. Required: ready_o=1 after E1, result_o=64'h0.
- Annul: assert annul_i for one cycle at iteration 10. Required:
  - FREE on the next edge; ready_o never rises.
  - A fresh 100/7 request afterwards completes normally with {2, 14}.
- Reset mid-operation: drive rst=0 at iteration 20. Required: the next edge gives ready_o=0, result_o=0, state FREE; a subsequent request completes correctly.
- Handshake: hold start_i 5 cycles past ready. Required: result_o stays stable. Drop start_i and require ready_o=0 and result_o=0 after one edge.
